seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle radix-2 restoring divider for the CPU's MULT/DIV unit; it generalises the 32-bit divider. Computes A/B for WIDTH-bit operands in signed (two's complement) or unsigned mode, one quotient bit per cycle. Results go to HI (remainder) and LO (quotient), with a start/stop handshake to the control FSM and a divide-by-zero flag.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64. Counter width is a derived localparam, $clog2(WIDTH+1).
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- w_DivStart  in  1  request; sampled only in IDLE.
- w_Signed  in  1  1 = signed division, 0 = unsigned; sampled with w_DivStart.
- w_A  in  WIDTH  dividend; sampled with w_DivStart.
- w_B  in  WIDTH  divisor; sampled with w_DivStart.
- w_DivStop  out  1  one-cycle completion pulse.
- w_DivBusy  out  1  high from the accept edge until the w_DivStop cycle, inclusive.
- w_DivZero  out  1  set when B == 0 for the last completed operation.
- w_DIVHI  out  WIDTH  remainder.
- w_DIVLO  out  WIDTH  quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If w_DivStart=1: latch the operand magnitudes N=|A| and D=|B| (absolute value only in signed mode), latch sign_q=A[msb]^B[msb] and sign_r=A[msb] (both 0 when unsigned), and clear Q, R and w_DivZero.
  - If B==0, go to FIX with the zero flag pending. Otherwise load cnt=WIDTH and go to RUN.
- RUN, one step per cycle:
  - R={R[WIDTH-1:0],N[cnt-1]}. R is WIDTH+1 bits, so the shifted value never overflows.
  - If R>=D: R=R-D and Q[cnt-1]=1.
  - Decrement cnt; at cnt==1, go to FIX after this step.
- FIX, with results registered:
  - Divide by zero: w_DivZero=1, w_DIVHI=A (raw), w_DIVLO=all ones.
  - Otherwise: w_DIVLO = sign_q ? -Q : Q and w_DIVHI = sign_r ? -R : R, both truncated to WIDTH.
  - Go to DONE.
- DONE: w_DivStop=1 for this cycle only; go to IDLE.
- Signed overflow (most-negative / -1): quotient wraps to most-negative, remainder 0, w_DivZero=0. This falls out of the unsigned core with no special case.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- w_DIVHI, w_DIVLO and w_DivZero hold their values until the next completion or reset.
- w_DivStart outside IDLE is ignored; it neither aborts nor queues.
- w_DivStart held high: a new operation is accepted in the first IDLE cycle after DONE.

## Timing
- Reset values: w_DivStop=0, w_DivBusy=0, w_DivZero=0, w_DIVHI=0, w_DIVLO=0, state IDLE, Q/R/N/D=0.
- Accept edge E0 (IDLE with start=1). For B≠0: RUN edges E1..E_WIDTH, FIX at E_WIDTH+1, w_DivStop high in the cycle after E_WIDTH+1.
  - Latency from accept to stop is WIDTH+2 cycles (34 at WIDTH=32).
- B==0: FIX at E1, w_DivStop high after E1; latency 2 cycles.
- Results are valid no later than the w_DivStop cycle and are stable from then on.
- Reset during any state: IDLE next cycle, all outputs back to reset values, no w_DivStop pulse, any in-flight operation discarded.
- Reset and w_DivStart in the same cycle: reset wins and the start is dropped.

## Configuration
- DIV_SIGNED_EN:
  - Defined: signed-mode logic (abs on input, negate on output) is compiled in, and w_Signed selects the mode.
  - Undefined: w_Signed is ignored (port kept), every operation is unsigned, and the abs/negate logic is removed.

## Structure
- Package div_pkg: state enum typedef (IDLE, RUN, FIX, DONE), localparam MIN_WIDTH=4, and function abs_w / negate helpers parametrised by WIDTH.
- One sub-module, div_step: combinational single restoring step. Inputs: R (WIDTH+1), D (WIDTH), next dividend bit. Outputs: next R and quotient bit. The top-level holds the FSM, counter and registers.

## Test plan
- Signed 100/7 at WIDTH=32 -> LO=14, HI=2, w_DivZero=0, w_DivStop exactly 34 cycles after the accept edge, busy high throughout.
- Signed -100/7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE. Signed 100/-7 -> LO=0xFFFFFFF2, HI=2. Signed -100/-7 -> LO=14, HI=0xFFFFFFFE.
- A=0x80000000, B=0xFFFFFFFF: signed -> LO=0x80000000, HI=0, no DivZero; unsigned -> LO=0, HI=0x80000000. Unsigned 0xFFFFFFFF/3 -> LO=0x55555555, HI=0.
- A=5, B=0 -> w_DivZero=1, HI=5, LO=0xFFFFFFFF, w_DivStop 2 cycles after accept. Next start with 9/3 clears DivZero -> LO=3, HI=0.
- Reset at RUN cycle 10 -> all outputs 0, no w_DivStop. A start pulse mid-RUN of a 50/5 operation is ignored -> LO=10, HI=0 at the normal time.
- WIDTH=8, signed -128/3 -> LO=0xD6 (-42), HI=0xFE (-2), latency 10 cycles. Without DIV_SIGNED_EN, the same operands -> LO=42, HI=2.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential radix-2 restoring divider.
//   div_state_e : FSM state encoding (IDLE, RUN, FIX, DONE)
//   MIN_WIDTH   : smallest supported operand width
//   MAX_WIDTH   : widest supported operand width (helpers work on this width)
//   negate      : two's complement negation on a MAX_WIDTH word
//   abs_w       : magnitude of a 'width'-bit two's complement value held in
//                 the low bits of a MAX_WIDTH word
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic word_t negate(input word_t v);
        return ~v + word_t'(1);
    endfunction

    // Callers keep only the low 'width' bits of the result.
    function automatic word_t abs_w(input word_t v, input int unsigned width);
        return v[IDX_W'(width - 1)] ? negate(v) : v;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/stop handshake and operand/result bus between the MULT/DIV control FSM
// (master) and the sequential divider (slave).
//   w_DivStart, w_Signed, w_A, w_B        : master -> divider
//   w_DivStop, w_DivBusy, w_DivZero,
//   w_DIVHI (remainder), w_DIVLO (quotient): divider -> master
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             w_DivStart;
    logic             w_Signed;
    logic [WIDTH-1:0] w_A;
    logic [WIDTH-1:0] w_B;
    logic             w_DivStop;
    logic             w_DivBusy;
    logic             w_DivZero;
    logic [WIDTH-1:0] w_DIVHI;
    logic [WIDTH-1:0] w_DIVLO;

    modport master (
        output w_DivStart, w_Signed, w_A, w_B,
        input  w_DivStop, w_DivBusy, w_DivZero, w_DIVHI, w_DIVLO
    );

    modport slave (
        input  w_DivStart, w_Signed, w_A, w_B,
        output w_DivStop, w_DivBusy, w_DivZero, w_DIVHI, w_DIVLO
    );
endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   r_in  [WIDTH:0]   : partial remainder (always < d_in, so its MSB is 0)
//   d_in  [WIDTH-1:0] : divisor magnitude
//   n_bit             : next dividend bit, shifted in at the LSB
//   r_out [WIDTH:0]   : partial remainder after the trial subtraction
//   q_bit             : resulting quotient bit
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             n_bit,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_r_msb;

    // The incoming remainder is below the divisor, so its top bit is always 0
    // and dropping it in the shift loses nothing.
    assign unused_r_msb = r_in[WIDTH];

    always_comb begin
        shifted = {r_in[WIDTH-1:0], n_bit};
        diff    = shifted - {1'b0, d_in};
        q_bit   = (shifted >= {1'b0, d_in});
        r_out   = q_bit ? diff : shifted;
    end
endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring divider: one quotient bit per clock.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : seq_divider_if.slave (start/operands in; stop/busy/zero/HI/LO out)
// Latency from the accept edge to w_DivStop is WIDTH+2 cycles, or 2 cycles for
// a zero divisor. HI holds the remainder (sign of the dividend), LO the quotient
// (truncated toward zero).
// Build option: define DIV_SIGNED_EN to compile in signed mode (w_Signed then
// selects signed/unsigned); otherwise every operation is unsigned.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          Clock,
    input logic          Reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             zero_pend_q, zero_pend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic [WIDTH-1:0] n_in, d_in;
    logic [WIDTH-1:0] hi_mag, hi_res, lo_res;
    logic [WIDTH:0]   step_r;
    logic             step_q;

    assign accept = (state_q == IDLE) && bus.w_DivStart;

    // On a zero divisor N is never shifted, and magnitude N with the dividend
    // sign reapplied reproduces the raw dividend for HI.
    assign hi_mag = zero_pend_q ? n_q : r_q[WIDTH-1:0];

    // N and Q are shift registers: the MSB of N is always dividend bit cnt-1,
    // and the quotient bit shifted in lands at position cnt-1 after WIDTH steps.
    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .d_in  (d_q),
        .n_bit (n_q[WIDTH-1]),
        .r_out (step_r),
        .q_bit (step_q)
    );

`ifdef DIV_SIGNED_EN
    logic quot_neg_q, quot_neg_d;
    logic rem_neg_q, rem_neg_d;

    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v);
        word_t e;
        e            = '0;
        e[WIDTH-1:0] = v;
        e            = abs_w(e, WIDTH);
        return e[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] neg_op(input logic [WIDTH-1:0] v);
        word_t e;
        e            = '0;
        e[WIDTH-1:0] = v;
        e            = negate(e);
        return e[WIDTH-1:0];
    endfunction

    always_comb begin
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        if (accept) begin
            quot_neg_d = bus.w_Signed & (bus.w_A[WIDTH-1] ^ bus.w_B[WIDTH-1]);
            rem_neg_d  = bus.w_Signed & bus.w_A[WIDTH-1];
        end
        n_in   = bus.w_Signed ? abs_op(bus.w_A) : bus.w_A;
        d_in   = bus.w_Signed ? abs_op(bus.w_B) : bus.w_B;
        lo_res = quot_neg_q ? neg_op(q_q) : q_q;
        hi_res = rem_neg_q ? neg_op(hi_mag) : hi_mag;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.w_Signed;
    assign n_in          = bus.w_A;
    assign d_in          = bus.w_B;
    assign lo_res        = q_q;
    assign hi_res        = hi_mag;
`endif

    always_comb begin
        // NOTE: every variable gets a hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        d_d         = d_q;
        r_d         = r_q;
        q_d         = q_q;
        zero_pend_d = zero_pend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        zero_d      = zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.w_DivStart) begin
                    n_d         = n_in;
                    d_d         = d_in;
                    r_d         = '0;
                    q_d         = '0;
                    zero_d      = 1'b0;
                    zero_pend_d = (bus.w_B == '0);
                    if (bus.w_B == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_q};
                n_d   = {n_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_pend_q) begin
                    zero_d = 1'b1;
                    hi_d   = hi_res;
                    lo_d   = '1;
                end else begin
                    hi_d = hi_res;
                    lo_d = lo_res;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            zero_pend_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            d_q         <= d_d;
            r_q         <= r_d;
            q_q         <= q_d;
            zero_pend_q <= zero_pend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.w_DivStop = (state_q == DONE);
    assign bus.w_DivBusy = (state_q != IDLE);
    assign bus.w_DivZero = zero_q;
    assign bus.w_DIVHI   = hi_q;
    assign bus.w_DIVLO   = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8. Expected
// results (including the unsigned-only values when DIV_SIGNED_EN is not
// defined) are hand-computed constants pushed at issue time; monitors pop and
// compare on each w_DivStop.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [63:0] lo;
        logic [63:0] hi;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q32[$];
    exp_t q8[$];
    bit   busy_ok32 = 1'b1;
    bit   busy_ok8  = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider_if #(.WIDTH(32)) bus32 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(32)) dut32 (.Clock(clk), .Reset(rst), .bus(bus32.slave));
    seq_divider #(.WIDTH(8))  dut8  (.Clock(clk), .Reset(rst), .bus(bus8.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [63:0] lo,
                         input logic [63:0] hi, input logic z, input bit busy_ok);
        check($sformatf("%s#%0d LO", tag, e.id), lo, e.lo);
        check($sformatf("%s#%0d HI", tag, e.id), hi, e.hi);
        check($sformatf("%s#%0d zero", tag, e.id), 64'(z), 64'(e.zero));
        check($sformatf("%s#%0d latency", tag, e.id), 64'(cyc - e.acc + 1), 64'(e.lat));
        check($sformatf("%s#%0d busy", tag, e.id), 64'(busy_ok), 64'(1));
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q32.size() > 0 && cyc >= q32[0].acc && !bus32.w_DivBusy) busy_ok32 = 1'b0;
            if (bus32.w_DivStop) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w32 stop: got unexpected pulse at cycle %0d expected none", cyc);
                end else begin
                    e = q32.pop_front();
                    score("w32", e, 64'(bus32.w_DIVLO), 64'(bus32.w_DIVHI), bus32.w_DivZero, busy_ok32);
                    busy_ok32 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q8.size() > 0 && cyc >= q8[0].acc && !bus8.w_DivBusy) busy_ok8 = 1'b0;
            if (bus8.w_DivStop) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w8 stop: got unexpected pulse at cycle %0d expected none", cyc);
                end else begin
                    e = q8.pop_front();
                    score("w8", e, 64'(bus8.w_DIVLO), 64'(bus8.w_DIVHI), bus8.w_DivZero, busy_ok8);
                    busy_ok8 = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle(input bit w8);
        for (int i = 0; i < 100; i++) begin
            if (!(w8 ? bus8.w_DivBusy : bus32.w_DivBusy)) break;
            @(negedge clk);
        end
    endtask

    // Drive one start pulse at a negedge; the following posedge is the accept edge.
    task automatic issue(input bit w8, input bit sgn, input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            bus8.w_DivStart = 1'b1; bus8.w_Signed = sgn;
            bus8.w_A = a[7:0];      bus8.w_B = b[7:0];
        end else begin
            bus32.w_DivStart = 1'b1; bus32.w_Signed = sgn;
            bus32.w_A = a[31:0];     bus32.w_B = b[31:0];
        end
    endtask

    task automatic release_start();
        bus32.w_DivStart = 1'b0;
        bus8.w_DivStart  = 1'b0;
    endtask

    task automatic run_op(input int id, input bit w8, input bit sgn, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] lo, input logic [63:0] hi,
                          input bit z, input int lat);
        exp_t e;
        wait_idle(w8);
        issue(w8, sgn, a, b);
        e = '{id: id, lo: lo, hi: hi, zero: z, lat: lat, acc: cyc + 1};
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
        @(negedge clk);
        release_start();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        if (q32.size() != 0 || q8.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d results pending expected 0", q32.size() + q8.size());
            q32.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus32.w_DivStart = 1'b0; bus32.w_Signed = 1'b0; bus32.w_A = '0; bus32.w_B = '0;
        bus8.w_DivStart  = 1'b0; bus8.w_Signed  = 1'b0; bus8.w_A  = '0; bus8.w_B  = '0;
        repeat (3) @(negedge clk);
        check("reset stop",  64'(bus32.w_DivStop), 64'(0));
        check("reset busy",  64'(bus32.w_DivBusy), 64'(0));
        check("reset zero",  64'(bus32.w_DivZero), 64'(0));
        check("reset HI",    64'(bus32.w_DIVHI),   64'(0));
        check("reset LO",    64'(bus32.w_DIVLO),   64'(0));
        rst = 1'b0;
        @(negedge clk);

        // WIDTH=32 directed vectors
        run_op(1, 0, 1, 64'd100, 64'd7, 64'd14, 64'd2, 0, 34);
        wait_done();
        run_op(2, 0, 1, 64'hFFFFFF9C, 64'd7,
               SEN ? 64'hFFFFFFF2 : 64'h24924916, SEN ? 64'hFFFFFFFE : 64'd2, 0, 34);
        wait_done();
        run_op(3, 0, 1, 64'd100, 64'hFFFFFFF9,
               SEN ? 64'hFFFFFFF2 : 64'd0, SEN ? 64'd2 : 64'd100, 0, 34);
        wait_done();
        run_op(4, 0, 1, 64'hFFFFFF9C, 64'hFFFFFFF9,
               SEN ? 64'd14 : 64'd0, SEN ? 64'hFFFFFFFE : 64'hFFFFFF9C, 0, 34);
        wait_done();
        run_op(5, 0, 1, 64'h80000000, 64'hFFFFFFFF,
               SEN ? 64'h80000000 : 64'd0, SEN ? 64'd0 : 64'h80000000, 0, 34);
        wait_done();
        run_op(6, 0, 0, 64'h80000000, 64'hFFFFFFFF, 64'd0, 64'h80000000, 0, 34);
        wait_done();
        run_op(7, 0, 0, 64'hFFFFFFFF, 64'd3, 64'h55555555, 64'd0, 0, 34);
        wait_done();
        run_op(8, 0, 0, 64'd5, 64'd0, 64'hFFFFFFFF, 64'd5, 1, 2);
        wait_done();
        run_op(9, 0, 1, 64'hFFFFFFFB, 64'd0, 64'hFFFFFFFF, 64'hFFFFFFFB, 1, 2);
        wait_done();
        run_op(10, 0, 0, 64'd9, 64'd3, 64'd3, 64'd0, 0, 34);
        wait_done();

        // Start pulse mid-RUN must be ignored
        run_op(11, 0, 0, 64'd50, 64'd5, 64'd10, 64'd0, 0, 34);
        repeat (5) @(negedge clk);
        issue(0, 0, 64'd7, 64'd7);
        @(negedge clk);
        release_start();
        wait_done();

        // WIDTH=8 vectors
        run_op(12, 1, 1, 64'h80, 64'd3, SEN ? 64'hD6 : 64'h2A, SEN ? 64'hFE : 64'h02, 0, 10);
        wait_done();
        run_op(13, 1, 0, 64'hFF, 64'h10, 64'h0F, 64'h0F, 0, 10);
        wait_done();

        // Reset at RUN cycle 10 discards the operation and clears all outputs
        wait_idle(0);
        issue(0, 0, 64'd1000, 64'd3);
        @(negedge clk);
        release_start();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 64'(bus32.w_DivBusy), 64'(0));
        check("midrst stop", 64'(bus32.w_DivStop), 64'(0));
        check("midrst HI",   64'(bus32.w_DIVHI),   64'(0));
        check("midrst LO",   64'(bus32.w_DIVLO),   64'(0));
        check("midrst w8 LO", 64'(bus8.w_DIVLO),   64'(0));
        check("midrst w8 HI", 64'(bus8.w_DIVHI),   64'(0));
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Reset and start in the same cycle: the start is dropped
        rst = 1'b1;
        issue(0, 0, 64'd20, 64'd4);
        @(negedge clk);
        rst = 1'b0;
        release_start();
        check("rst+start busy", 64'(bus32.w_DivBusy), 64'(0));
        repeat (40) @(negedge clk);

        // A fresh operation after reset still works
        run_op(14, 0, 0, 64'd1000, 64'd3, 64'd333, 64'd1, 0, 34);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
